// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : First-word-fall-through receive buffer behind the UART receiver,
//            with fill level, sticky overrun flag and threshold interrupt.
// Revision : 1.0
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4,
    parameter int THRESHOLD = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_data_ready,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_rd_en,
    output logic                 o_rd_valid,
    output logic [DATA_BITS-1:0] o_rd_data,
    input  logic                 i_flush,
    input  logic                 i_clr_overrun,
    output logic                 o_overrun,
    output logic [ADDR_BITS:0]   o_count,
    output logic                 o_full,
    output logic                 o_irq
);

    localparam int                 DEPTH    = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] C_DEPTH  = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0] C_THRESH = (ADDR_BITS + 1)'(THRESHOLD);

    logic [DATA_BITS-1:0] mem_q [DEPTH];

    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   count_q,  count_d;
    logic                 overrun_q, overrun_d;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_ovf;

    assign w_full = (count_q == C_DEPTH);
    assign w_pop  = i_rd_en && (count_q != '0);
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push = i_data_ready && (!w_full || w_pop);
    assign w_ovf  = i_data_ready && w_full && !w_pop;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // A fresh overflow outranks a clear in the same cycle.
        if (w_ovf) begin
            overrun_d = 1'b1;
        end else if (i_clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_rd_valid = (count_q != '0);
    assign o_rd_data  = mem_q[rd_ptr_q];
    assign o_overrun  = overrun_q;
    assign o_count    = count_q;
    assign o_full     = w_full;
    assign o_irq      = (count_q >= C_THRESH) || overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed and randomized checks of uart_rx_fifo against a queue model.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int THR   = 8;

    logic       clk;
    logic       rst;
    logic       i_data_ready;
    logic [7:0] i_data;
    logic       i_rd_en;
    logic       o_rd_valid;
    logic [7:0] o_rd_data;
    logic       i_flush;
    logic       i_clr_overrun;
    logic       o_overrun;
    logic [4:0] o_count;
    logic       o_full;
    logic       o_irq;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_q[$];
    bit         m_ovr;

    uart_rx_fifo #(
        .DATA_BITS (8),
        .ADDR_BITS (4),
        .THRESHOLD (THR)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_data_ready  (i_data_ready),
        .i_data        (i_data),
        .i_rd_en       (i_rd_en),
        .o_rd_valid    (o_rd_valid),
        .o_rd_data     (o_rd_data),
        .i_flush       (i_flush),
        .i_clr_overrun (i_clr_overrun),
        .o_overrun     (o_overrun),
        .o_count       (o_count),
        .o_full        (o_full),
        .o_irq         (o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = m_q.size();
        chk({tag, ".valid"},   32'(o_rd_valid), 32'(n != 0));
        chk({tag, ".count"},   32'(o_count),    32'(n));
        chk({tag, ".full"},    32'(o_full),     32'(n == DEPTH));
        chk({tag, ".overrun"}, 32'(o_overrun),  32'(m_ovr));
        chk({tag, ".irq"},     32'(o_irq),      32'((n >= THR) || m_ovr));
        if (n != 0) begin
            chk({tag, ".data"}, 32'(o_rd_data), 32'(m_q[0]));
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic cycle(input string tag, input bit dr, input logic [7:0] d,
                         input bit rd, input bit fl, input bit clr);
        bit pop, ovf;
        i_data_ready  = dr;
        i_data        = d;
        i_rd_en       = rd;
        i_flush       = fl;
        i_clr_overrun = clr;
        pop = rd && (m_q.size() != 0);
        ovf = dr && (m_q.size() == DEPTH) && !pop;
        @(posedge clk);
        #1;
        if (fl) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (dr && !ovf) m_q.push_back(d);
        end
        if (ovf) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        i_data_ready  = 1'b0;
        i_rd_en       = 1'b0;
        i_flush       = 1'b0;
        i_clr_overrun = 1'b0;
        check_all(tag);
    endtask

    initial begin
        bit dr, rd, fl, clr;
        int pp, rp;
        rst           = 1'b1;
        i_data_ready  = 1'b0;
        i_data        = 8'h00;
        i_rd_en       = 1'b0;
        i_flush       = 1'b0;
        i_clr_overrun = 1'b0;
        m_ovr         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("reset");

        // single word round trip
        cycle("a5_push", 1, 8'hA5, 0, 0, 0);
        cycle("a5_pop",  0, 8'h00, 1, 0, 0);

        // fill, overflow, drain in order
        for (int i = 0; i < 16; i++) cycle("fill", 1, 8'(i), 0, 0, 0);
        cycle("ovf_ff", 1, 8'hFF, 0, 0, 0);
        for (int i = 0; i < 16; i++) cycle("drain", 0, 8'h00, 1, 0, 0);
        cycle("clr", 0, 8'h00, 0, 0, 1);

        // pointer wrap
        for (int i = 0; i < 10; i++) cycle("wrap_p10", 1, 8'(8'h20 + i), 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle("wrap_r10", 0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 12; i++) cycle("wrap_p12", 1, 8'(8'h40 + i), 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle("wrap_r12", 0, 8'h00, 1, 0, 0);

        // full with simultaneous push and pop
        for (int i = 0; i < 16; i++) cycle("fill2", 1, 8'(8'h60 + i), 0, 0, 0);
        cycle("full_pushpop", 1, 8'h55, 1, 0, 0);
        for (int i = 0; i < 16; i++) cycle("drain2", 0, 8'h00, 1, 0, 0);

        // empty pop ignored with same-cycle push, then flush beats push
        cycle("empty_rd_push", 1, 8'h3C, 1, 0, 0);
        cycle("flush_push",    1, 8'h77, 0, 1, 0);

        // overflow vs clear priority
        for (int i = 0; i < 16; i++) cycle("fill3", 1, 8'(8'h80 + i), 0, 0, 0);
        cycle("ovf",         1, 8'hEE, 0, 0, 0);
        cycle("ovf_and_clr", 1, 8'hEF, 0, 0, 1);
        cycle("clr_alone",   0, 8'h00, 0, 0, 1);
        cycle("flush3",      0, 8'h00, 0, 1, 0);

        // asynchronous reset mid-fill
        for (int i = 0; i < 5; i++) cycle("fill5", 1, 8'(8'hC0 + i), 0, 0, 0);
        cycle("set_ovr_src", 0, 8'h00, 0, 0, 0);
        rst = 1'b1;
        #2;
        m_q.delete();
        m_ovr = 1'b0;
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("after_rst");

        // randomized traffic: fill-heavy then drain-heavy phases
        for (int ph = 0; ph < 4; ph++) begin
            pp = (ph % 2 == 0) ? 75 : 30;
            rp = (ph % 2 == 0) ? 35 : 75;
            for (int i = 0; i < 250; i++) begin
                fl  = ($urandom_range(99) < 2);
                clr = ($urandom_range(99) < 5);
                dr  = !fl && ($urandom_range(99) < pp);
                rd  = ($urandom_range(99) < rp);
                cycle("rand", dr, 8'($urandom), rd, fl, clr);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer that sits directly downstream of the UART receiver.
- Captures each byte the receiver presents with its one-cycle data-ready strobe and stores it in a first-word-fall-through FIFO.
- Presents the FIFO head to the bus-side logic (Wishbone register bank) through a valid/read-enable handshake.
- Reports fill level, a sticky overrun flag and a threshold interrupt.

Parameters:
- DATA_BITS, 8, width of each received word; matches the receiver data width.
- ADDR_BITS, 4, FIFO address width; DEPTH = 2**ADDR_BITS = 16 entries.
- THRESHOLD, 8, fill level at or above which o_irq asserts; legal range 1..DEPTH.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst  input  1  asynchronous active-high reset.
- i_data_ready  input  1  one-cycle strobe from the receiver: new word on i_data.
- i_data  input  DATA_BITS  received word, valid only while i_data_ready is high.
- i_rd_en  input  1  consumer pops the head word; effective only when o_rd_valid is high.
- o_rd_valid  output  1  FIFO not empty; o_rd_data holds the head word.
- o_rd_data  output  DATA_BITS  head word, first-word-fall-through.
- i_flush  input  1  synchronous flush of all stored words.
- i_clr_overrun  input  1  clears the sticky overrun flag.
- o_overrun  output  1  sticky: one or more words were dropped because the FIFO was full.
- o_count  output  ADDR_BITS+1  current number of stored words, 0..DEPTH.
- o_full  output  1  o_count == DEPTH.
- o_irq  output  1  (o_count >= THRESHOLD) OR o_overrun.

Behaviour:
Reset:
- i_rst high, asynchronous: wr_ptr=0, rd_ptr=0, count=0, o_overrun=0.
- Resulting outputs: o_rd_valid=0, o_full=0, o_irq=0, o_count=0.
- Storage array is not reset. o_rd_data is don't-care while o_rd_valid=0.
- Reset asserted mid-stream discards all contents immediately.

Storage:
- DEPTH x DATA_BITS array. Pointers are ADDR_BITS wide and wrap naturally from DEPTH-1 to 0.
- count is a separate ADDR_BITS+1 register.

Push:
- On a rising edge with i_data_ready=1 and the push accepted: mem[wr_ptr]<=i_data, wr_ptr increments.
- A push is accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.

Pop:
- pop = i_rd_en AND o_rd_valid. On pop, rd_ptr increments.
- i_rd_en while empty is ignored, including when a push happens in the same cycle.

Count update:
- push only: +1. Pop only: -1. Both: unchanged. Neither: unchanged.

Output timing:
- o_rd_valid = (count != 0), registered via count.
- o_rd_data = mem[rd_ptr] (combinational read, FWFT).
- Latency from i_data_ready strobe to o_rd_valid high and data visible: 1 clock.

Overrun:
- i_data_ready while count==DEPTH with no simultaneous pop: word dropped, pointers unchanged, o_overrun<=1 on that edge.
- o_overrun stays high until i_clr_overrun.
- i_clr_overrun and a new overflow in the same cycle: set wins, o_overrun stays 1.

Flush:
- i_flush=1: wr_ptr<=0, rd_ptr<=0, count<=0.
- Flush overrides any simultaneous push and pop; the incoming word is discarded.
- o_overrun is not affected by flush.

Other outputs:
- o_full and o_irq are combinational from registered count and o_overrun.

Strobe width:
- The receiver strobe is one cycle wide. A strobe held high for N cycles is treated as N pushes (no edge detection).

Test Plan:
- Reset, then strobe 0xA5 once -> next cycle o_rd_valid=1, o_rd_data=0xA5, o_count=1; pulse i_rd_en -> o_rd_valid=0, o_count=0.
- Push 0x00..0x0F (16 words) -> o_full=1, o_count=16, o_irq=1 from the 8th push onward. Push 0xFF -> o_overrun=1, count stays 16. Drain 16 -> reads 0x00..0x0F in order, 0xFF never appears.
- Pointer wrap: push 10, pop 10, push 12, pop 12 -> output sequence is intact and ordered, o_count returns to 0.
- Full with simultaneous push 0x55 and pop -> o_count stays 16, no overrun, 0x55 appears as the 16th subsequent read.
- Empty with i_rd_en=1 and push 0x3C in the same cycle -> 0x3C retained, o_count=1. Then i_flush together with push 0x77 -> o_count=0, o_rd_valid=0.
- o_overrun=1, then i_clr_overrun asserted in the same cycle as an overflowing push -> o_overrun remains 1. Clear alone -> 0. Assert i_rst mid-fill (count=5) -> all outputs 0 asynchronously, before the next clock edge.
